// File: rtl/interrupt_controller.sv
// interrupt_controller: 6502 interrupt entry sequencer. It synchronises the
// NMI/IRQ pins, detects NMI edges, masks IRQ with the I flag and requests BRK
// injection. During the BRK microcode it supplies the vector low byte, the
// pushed B bit and write inhibit for the reset sequence.
// Ports: sys_clock/rst (sync, active-low); clk_ph1 state-advance enable;
//   nmi_n/irq_n async pins; i_flag, cycle, next_cycle from the core;
//   int_flag, vec_lo, b_flag, wr_inhibit, int_active to the core.
module interrupt_controller #(
  parameter logic [2:0] BRK_LAST  = 3'd6,
  parameter logic [2:0] VEC_FETCH = 3'd5
) (
  input  logic       sys_clock,
  input  logic       rst,
  input  logic       clk_ph1,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic [2:0] cycle,
  input  logic [2:0] next_cycle,
  output logic       int_flag,
  output logic [7:0] vec_lo,
  output logic       b_flag,
  output logic       wr_inhibit,
  output logic       int_active
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVICE   = 2'd1,
    RESET_SEQ = 2'd2
  } state_t;

  state_t state, state_next;

  logic nmi_meta, nmi_s, irq_meta, irq_s;
  logic nmi_prev, nmi_pending, irq_level, vec_nmi;
  logic nmi_edge, accept, hijack;

  // Pin synchronisers run on every sys_clock edge, independent of clk_ph1.
  always_ff @(posedge sys_clock) begin
    if (!rst) begin
      nmi_meta <= 1'b1;
      nmi_s    <= 1'b1;
      irq_meta <= 1'b1;
      irq_s    <= 1'b1;
    end else begin
      nmi_meta <= nmi_n;
      nmi_s    <= nmi_meta;
      irq_meta <= irq_n;
      irq_s    <= irq_meta;
    end
  end

  assign nmi_edge = nmi_prev & ~nmi_s;

  always_ff @(posedge sys_clock) begin
    if (!rst) begin
      state <= RESET_SEQ;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hijack     = 1'b0;
    int_flag   = 1'b0;
    vec_lo     = 8'hFE;
    b_flag     = 1'b0;
    wr_inhibit = 1'b0;
    int_active = 1'b1;
    case (state)
      IDLE: begin
        // Idle outputs double as the software BRK values (B=1, IRQ vector).
        int_flag   = nmi_pending | irq_level;
        b_flag     = 1'b1;
        int_active = 1'b0;
        if (clk_ph1 && next_cycle == 3'd1 && int_flag) begin
          accept     = 1'b1;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        vec_lo = vec_nmi ? 8'hFA : 8'hFE;
        // An NMI arriving before the vector fetch steals an IRQ sequence.
        if (clk_ph1 && cycle < VEC_FETCH && !vec_nmi && nmi_pending) begin
          hijack = 1'b1;
        end
        if (clk_ph1 && cycle == BRK_LAST) begin
          state_next = IDLE;
        end
      end
      RESET_SEQ: begin
        vec_lo     = 8'hFC;
        wr_inhibit = 1'b1;
        if (clk_ph1 && cycle == BRK_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = RESET_SEQ;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (!rst) begin
      nmi_prev    <= 1'b1;
      nmi_pending <= 1'b0;
      irq_level   <= 1'b0;
      vec_nmi     <= 1'b0;
    end else if (clk_ph1) begin
      nmi_prev  <= nmi_s;
      // IRQ is level sensitive and re-polled every phase, never latched.
      irq_level <= ~irq_s & ~i_flag;
      // A fresh edge wins over a same-cycle clear so a second NMI is kept.
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end else if ((accept && nmi_pending) || hijack) begin
        nmi_pending <= 1'b0;
      end
      if (accept) begin
        vec_nmi <= nmi_pending;
      end else if (hijack) begin
        vec_nmi <= 1'b1;
      end
    end
  end

endmodule
